// File: rtl/drum_mon_pkg.sv
// drum_mon_pkg: shared state encoding, default sizes and error helper for the DRUM error monitor
package drum_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_CNT_W = 32;
  function automatic logic [64:0] ext(input logic [63:0] x, input int pw, input logic signed_mode);
    logic [64:0] m;
    m = {65{1'b1}} << pw;
    return (signed_mode && x[6'(pw-1)]) ? ({1'b0, x} | m) : ({1'b0, x} & ~m);
  endfunction
  // |exact - approx| for pw-bit products held in the low bits of 64-bit words
  function automatic logic [64:0] abs_err(input logic [63:0] exact, input logic [63:0] approx,
                                          input int pw, input logic signed_mode);
    logic [64:0] d;
    d = ext(exact, pw, signed_mode) - ext(approx, pw, signed_mode);
    return d[64] ? -d : d;
  endfunction
endpackage

// File: rtl/drum_exact_mul_pipe.sv
// drum_exact_mul_pipe: valid-tagged S1 capture, S2 exact product, S3 combinational |error|
module drum_exact_mul_pipe import drum_mon_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   r_approx,
  output logic                 s1_valid,
  output logic                 out_valid,
  output logic [2*WIDTH:0]     out_err,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b
);
  logic [WIDTH-1:0] a1, b1;
  logic [2*WIDTH-1:0] r1, r2, exact2;
  logic sa, sb;
  assign sa = SIGNED && a1[WIDTH-1];
  assign sb = SIGNED && b1[WIDTH-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      {a1, b1, r1} <= '0;
      {exact2, r2, out_a, out_b} <= '0;
    end else begin
      s1_valid <= in_valid && !flush;
      out_valid <= s1_valid && !flush;
      if (in_valid) {a1, b1, r1} <= {a, b, r_approx};
      if (s1_valid) begin
        exact2 <= {{WIDTH{sa}}, a1} * {{WIDTH{sb}}, b1};
        r2 <= r1;
        out_a <= a1;
        out_b <= b1;
      end
    end
  // S3 is combinational so the stats registers capture it on the retire edge
  assign out_err = (2*WIDTH+1)'(abs_err(64'(exact2), 64'(r2), 2*WIDTH, SIGNED));
endmodule

// File: rtl/drum_error_monitor.sv
// drum_error_monitor: run control FSM and error statistics over a stream of DRUM multiplier results
module drum_error_monitor import drum_mon_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit SIGNED = 1'b1,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] r_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [ACC_W-1:0]   err_sum,
  output logic [2*WIDTH:0]   err_max,
  output logic [WIDTH-1:0]   err_max_a,
  output logic [WIDTH-1:0]   err_max_b
);
  localparam int SW = (ACC_W > 2*WIDTH+1 ? ACC_W : 2*WIDTH+1) + 1;
  state_t state;
  logic [CNT_W-1:0] issued, target, issued_next;
  logic go, xfer, p_s1, p_v;
  logic [2*WIDTH:0] p_err;
  logic [WIDTH-1:0] p_a, p_b;
  logic [SW-1:0] sum_next;
  assign go = start && (state == IDLE || state == DONE);
  assign in_ready = (state == RUN) && (issued < target);
  assign xfer = in_valid && in_ready;
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = state == DONE;
  assign issued_next = issued + CNT_W'(xfer);
  assign sum_next = SW'(err_sum) + SW'(p_err);
  drum_exact_mul_pipe #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_pipe (
    .clk(clk), .rst(rst), .flush(go), .in_valid(xfer),
    .a(a), .b(b), .r_approx(r_approx),
    .s1_valid(p_s1), .out_valid(p_v), .out_err(p_err), .out_a(p_a), .out_b(p_b)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {issued, target, sample_cnt, mismatch_cnt} <= '0;
      {err_sum, err_max, err_max_a, err_max_b} <= '0;
    end else if (go) begin
      state <= RUN;
      issued <= '0;
      target <= num_samples;
      {sample_cnt, mismatch_cnt} <= '0;
      {err_sum, err_max, err_max_a, err_max_b} <= '0;
    end else begin
      issued <= issued_next;
      // DRAIN only waits on S1; an S2 entry retires on the same edge that enters DONE
      state <= (state == RUN && issued_next == target) ? DRAIN :
               (state == DRAIN && !p_s1) ? DONE : state;
      if (p_v) begin
        sample_cnt <= sample_cnt + 1'b1;
        mismatch_cnt <= mismatch_cnt + CNT_W'(p_err != '0);
        err_sum <= (sum_next > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : ACC_W'(sum_next);
        if (p_err > err_max) {err_max, err_max_a, err_max_b} <= {p_err, p_a, p_b};
      end
    end
endmodule

// File: tb/tb_drum_error_monitor.sv
// tb_drum_error_monitor: directed checks on a signed 48-bit-sum monitor and an unsigned 8-bit-sum monitor
module tb_drum_error_monitor;
  logic clk, rst, start, in_valid;
  logic [31:0] num_samples, r;
  logic [15:0] a, b;
  logic in_ready, busy, done, in_ready8, busy8, done8;
  logic [31:0] sample_cnt, mismatch_cnt, sc8, mc8;
  logic [47:0] err_sum;
  logic [7:0] es8;
  logic [32:0] err_max, em8;
  logic [15:0] err_max_a, err_max_b, ema8, emb8;
  int total = 0, bad = 0;

  drum_error_monitor #(.WIDTH(16), .SIGNED(1'b1), .ACC_W(48), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .r_approx(r), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt), .err_sum(err_sum), .err_max(err_max),
    .err_max_a(err_max_a), .err_max_b(err_max_b));

  drum_error_monitor #(.WIDTH(16), .SIGNED(1'b0), .ACC_W(8), .CNT_W(32)) dut8 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(in_ready8), .a(a), .b(b), .r_approx(r), .busy(busy8), .done(done8),
    .sample_cnt(sc8), .mismatch_cnt(mc8), .err_sum(es8), .err_max(em8),
    .err_max_a(ema8), .err_max_b(emb8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] n);
    start = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] sa, input logic [15:0] sb, input logic [31:0] sr);
    int k = 0;
    a = sa; b = sb; r = sr; in_valid = 1'b1;
    while (!in_ready && k < 20) begin tick(); k++; end
    if (!in_ready) chk("send_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (!done && k < max) begin tick(); k++; end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] sc, input logic [31:0] mc,
                           input logic [47:0] es, input logic [32:0] em,
                           input logic [15:0] ea, input logic [15:0] eb);
    chk({tag, "_cnt"}, 64'(sample_cnt), 64'(sc));
    chk({tag, "_mis"}, 64'(mismatch_cnt), 64'(mc));
    chk({tag, "_sum"}, 64'(err_sum), 64'(es));
    chk({tag, "_max"}, 64'(err_max), 64'(em));
    chk({tag, "_maxa"}, 64'(err_max_a), 64'(ea));
    chk({tag, "_maxb"}, 64'(err_max_b), 64'(eb));
  endtask

  initial begin
    int xfers, last_x, first_done;
    logic ready_c4;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0; a = '0; b = '0; r = '0;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_stats("rst", 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // 3*5=15 vs 14
    start_run(1);
    chk("t1_busy", 64'(busy), 64'd1);
    send(16'd3, 16'd5, 32'd14);
    wait_done("t1_done", 5);
    chk_stats("t1", 1, 1, 1, 1, 3, 5);
    chk("t1_u_sum", 64'(es8), 64'd1);

    start_run(3);
    send(16'hFFFF, 16'hFFFF, 32'h1);
    send(16'h8000, 16'h8000, 32'h40000000);
    send(16'h5555, 16'h5555, 32'h1C700000);
    wait_done("t2_done", 5);
    chk_stats("t2", 3, 1, 48'h18E39, 33'h18E39, 16'h5555, 16'h5555);
    chk("t2_u_mis", 64'(mc8), 64'd2);
    chk("t2_u_max", 64'(em8), 64'hFFFE0000);
    chk("t2_u_maxa", 64'(ema8), 64'hFFFF);
    chk("t2_u_sum", 64'(es8), 64'hFF);

    // hold in_valid high: exactly four transfers, done three cycles after the last
    start_run(4);
    a = 16'd1; b = 16'd1; r = 32'd1; in_valid = 1'b1;
    xfers = 0; last_x = -1; first_done = -1; ready_c4 = 1'bx;
    for (int i = 0; i < 10; i++) begin
      if (in_valid && in_ready) begin xfers++; last_x = i; end
      if (i == 4) ready_c4 = in_ready;
      if (done && first_done < 0) first_done = i;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_xfers", 64'(xfers), 64'd4);
    chk("t3_last", 64'(last_x), 64'd3);
    chk("t3_ready5", 64'(ready_c4), 64'd0);
    chk("t3_done_at", 64'(first_done), 64'd6);
    chk("t3_cnt", 64'(sample_cnt), 64'd4);
    chk("t3_mis", 64'(mismatch_cnt), 64'd0);

    // tie at |err|=7 keeps the first operands
    start_run(3);
    send(16'd2, 16'd3, 32'd13);
    send(16'd4, 16'd1, 32'd11);
    send(16'd1, 16'd1, 32'd2);
    wait_done("t4_done", 5);
    chk_stats("t4", 3, 3, 15, 7, 2, 3);
    chk("t4_u_maxa", 64'(ema8), 64'd2);
    chk("t4_u_maxb", 64'(emb8), 64'd3);

    // |100-300|=200 twice, with a start pulse in the middle of the run
    start_run(2);
    send(16'd10, 16'd10, 32'd300);
    start = 1'b1; num_samples = 7;
    tick();
    start = 1'b0;
    chk("t5_busy", 64'(busy), 64'd1);
    send(16'd10, 16'd10, 32'd300);
    wait_done("t5_done", 5);
    chk("t5_sum", 64'(err_sum), 64'd400);
    chk("t5_cnt", 64'(sample_cnt), 64'd2);
    chk("t5_u_sum", 64'(es8), 64'd255);
    chk("t5_u_cnt", 64'(sc8), 64'd2);
    chk("t5_u_done", 64'(done8), 64'd1);

    start_run(0);
    chk("t6_ready", 64'(in_ready), 64'd0);
    wait_done("t6_done", 2);
    chk_stats("t6", 0, 0, 0, 0, 0, 0);

    // reset in the middle of a run
    start_run(5);
    send(16'd3, 16'd3, 32'd0);
    send(16'd2, 16'd2, 32'd1);
    repeat (3) tick();
    chk("t7_pre_cnt", 64'(sample_cnt), 64'd2);
    chk("t7_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_stats("t7_rst", 0, 0, 0, 0, 0, 0);
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_ready", 64'(in_ready), 64'd0);
    chk("t7_rst_u_sum", 64'(es8), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    start_run(1);
    send(16'd7, 16'd7, 32'd49);
    wait_done("t7_done", 5);
    chk_stats("t7", 1, 0, 0, 0, 0, 0);
    chk("t7_u_ready", 64'(in_ready8), 64'(in_ready));
    chk("t7_u_busy", 64'(busy8), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
